// File: rtl/sliced_add_arbiter.sv
// Two-requester round-robin arbiter in front of a single 4-bit ripple slice that
// is time-shared to build a 4*SLICES-bit add, one slice per cycle.
module sliced_add_arbiter #(
  parameter int SLICES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0,
  input  logic [4*SLICES-1:0] a0,
  input  logic [4*SLICES-1:0] b0,
  input  logic                cin0,
  input  logic                req1,
  input  logic [4*SLICES-1:0] a1,
  input  logic [4*SLICES-1:0] b1,
  input  logic                cin1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                busy,
  output logic [4*SLICES-1:0] sum,
  output logic                cout,
  output logic                done,
  output logic                done_id
);

  localparam int W  = 4 * SLICES;
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Four chained full adders; returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
    logic [1:0] fa;
    logic       c;
    logic [3:0] s;
    c = ci;
    s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      fa   = full_add(x[i], y[i], c);
      s[i] = fa[0];
      c    = fa[1];
    end
    slice_add = {c, s};
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_id_q, done_id_d;
  logic            last_id_q, last_id_d;
  logic            gnt0_s, gnt1_s;
  logic [CW+1:0]   slice_base_s;
  logic [4:0]      slice_res_s;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_q == IDLE && !reset) begin
      gnt0_s = req0 & (~req1 | last_id_q);
      gnt1_s = req1 & (~req0 | ~last_id_q);
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // The shared slice always works on the slice selected by the counter.
  always_comb begin
    slice_base_s = {cnt_q, 2'b00};
    slice_res_s  = slice_add(a_q[slice_base_s +: 4], b_q[slice_base_s +: 4], carry_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    done_id_d = done_id_q;
    last_id_d = last_id_q;
    case (state_q)
      IDLE: begin
        if (gnt0_s) begin
          state_d   = ADD;
          a_d       = a0;
          b_d       = b0;
          carry_d   = cin0;
          done_id_d = 1'b0;
          last_id_d = 1'b0;
          cnt_d     = {CW{1'b0}};
        end else if (gnt1_s) begin
          state_d   = ADD;
          a_d       = a1;
          b_d       = b1;
          carry_d   = cin1;
          done_id_d = 1'b1;
          last_id_d = 1'b1;
          cnt_d     = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        sum_d[slice_base_s +: 4] = slice_res_s[3:0];
        carry_d                  = slice_res_s[4];
        if (cnt_q == LAST_SLICE) begin
          state_d = DONE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= {W{1'b0}};
      b_q       <= {W{1'b0}};
      sum_q     <= {W{1'b0}};
      carry_q   <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      done_id_q <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      done_id_q <= done_id_d;
      last_id_q <= last_id_d;
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = carry_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_sliced_add_arbiter.sv
// Self-checking bench for sliced_add_arbiter: directed scenarios plus a
// randomized run against a cycle-timeline reference model.
module tb_sliced_add_arbiter;

  localparam int S      = 4;
  localparam int W      = 4 * S;
  localparam int N_RAND = 3000;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, cin0 = 1'b0, cin1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, cout, done, done_id;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  sliced_add_arbiter #(.SLICES(S)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .sum(sum), .cout(cout), .done(done), .done_id(done_id)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return {W{1'b1}};
      1:       return {W{1'b0}};
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (sum !== '0 || cout !== 1'b0) begin n_fail++; $display("FAIL reset_sum: got %h/%b expected 0/0", sum, cout); end
    n_checks++; if (done_id !== 1'b0) begin n_fail++; $display("FAIL reset_done_id: got %b expected 0", done_id); end
    @(posedge clock); #1;
    reset = 1'b0; req1 = 1'b0;
    @(negedge clock);
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL first_cycle_gnt0: got %b expected 1", gnt0); end
    @(posedge clock); #1;
    req0 = 1'b0;
  endtask

  task automatic test_directed_ops();
    logic         vid [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] va  [3] = '{16'h1234, 16'hFFFF, 16'h000F};
    logic [W-1:0] vb  [3] = '{16'h0FFF, 16'h0000, 16'h0001};
    logic         vc  [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] vs  [3] = '{16'h2233, 16'h0000, 16'h0010};
    logic         vo  [3] = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int v = 0; v < 3; v++) begin
      if (vid[v] == 1'b0) begin
        req0 = 1'b1; a0 = va[v]; b0 = vb[v]; cin0 = vc[v];
      end else begin
        req1 = 1'b1; a1 = va[v]; b1 = vb[v]; cin1 = vc[v];
      end
      @(negedge clock);
      n_checks++; if (gnt0 !== ~vid[v] || gnt1 !== vid[v]) begin n_fail++; $display("FAIL op%0d_gnt: got %b%b expected %b%b", v, gnt0, gnt1, ~vid[v], vid[v]); end
      for (int k = 1; k <= S + 1; k++) begin
        @(posedge clock); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL op%0d_busy_k%0d: got %b expected 1", v, k, busy); end
        n_checks++; if (done !== (k == S + 1)) begin n_fail++; $display("FAIL op%0d_done_k%0d: got %b expected %b", v, k, done, (k == S + 1)); end
        if (k == S + 1) begin
          n_checks++; if (sum !== vs[v] || cout !== vo[v]) begin n_fail++; $display("FAIL op%0d_result: got %h/%b expected %h/%b", v, sum, cout, vs[v], vo[v]); end
          n_checks++; if (done_id !== vid[v]) begin n_fail++; $display("FAIL op%0d_done_id: got %b expected %b", v, done_id, vid[v]); end
        end
      end
      @(posedge clock); #1;
      @(negedge clock);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL op%0d_idle: got busy=%b done=%b expected 0 0", v, busy, done); end
      n_checks++; if (sum !== vs[v] || done_id !== vid[v]) begin n_fail++; $display("FAIL op%0d_hold: got %h/%b expected %h/%b", v, sum, done_id, vs[v], vid[v]); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_contention();
    logic [W:0] r0, r1;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
    a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
    r0 = ref_add(a0, b0, cin0);
    r1 = ref_add(a1, b1, cin1);
    for (int c = 0; c < 4 * (S + 2); c++) begin
      @(negedge clock);
      n_checks++; if (gnt0 !== (c % (2 * (S + 2)) == 0) || gnt1 !== (c % (2 * (S + 2)) == S + 2)) begin n_fail++; $display("FAIL contention_gnt_c%0d: got %b%b", c, gnt0, gnt1); end
      n_checks++; if (busy !== (c % (S + 2) != 0)) begin n_fail++; $display("FAIL contention_busy_c%0d: got %b expected %b", c, busy, (c % (S + 2) != 0)); end
      n_checks++; if (done !== (c % (S + 2) == S + 1)) begin n_fail++; $display("FAIL contention_done_c%0d: got %b expected %b", c, done, (c % (S + 2) == S + 1)); end
      if (c % (S + 2) == S + 1) begin
        n_checks++; if (done_id !== 1'((c / (S + 2)) % 2)) begin n_fail++; $display("FAIL contention_id_c%0d: got %b expected %0d", c, done_id, (c / (S + 2)) % 2); end
        n_checks++; if ({cout, sum} !== (((c / (S + 2)) % 2 == 0) ? r0 : r1)) begin n_fail++; $display("FAIL contention_result_c%0d: got %h/%b", c, sum, cout); end
      end
      @(posedge clock); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_abort();
    apply_reset();
    req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
    @(negedge clock);
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL abort_gnt: got %b expected 1", gnt0); end
    @(posedge clock); #1;
    req0 = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (busy !== 1'b1 || sum !== 16'h0003) begin n_fail++; $display("FAIL abort_pre: got busy=%b sum=%h expected 1 0003", busy, sum); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got busy=%b sum=%h cout=%b done=%b", busy, sum, cout, done); end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < S + 4; c++) begin
      @(negedge clock);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet_c%0d: got done=%b busy=%b expected 0 0", c, done, busy); end
      @(posedge clock); #1;
    end
    req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0;
    @(negedge clock);
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL abort_regnt: got %b expected 1", gnt0); end
    for (int k = 1; k <= S + 1; k++) begin
      @(posedge clock); #1;
      req0 = 1'b0;
    end
    @(negedge clock);
    n_checks++; if (done !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0 || done_id !== 1'b0) begin n_fail++; $display("FAIL abort_after: got done=%b sum=%h cout=%b id=%b expected 1 0100 0 0", done, sum, cout, done_id); end
    @(posedge clock); #1;
  endtask

  task automatic test_operand_stability();
    logic [W:0] r;
    apply_reset();
    req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
    r = ref_add(a0, b0, cin0);
    @(negedge clock);
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL stable_gnt: got %b expected 1", gnt0); end
    @(posedge clock); #1;
    req0 = 1'b0; a0 = {W{1'b1}}; b0 = {W{1'b1}}; cin0 = ~cin0;
    for (int k = 2; k <= S + 1; k++) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    n_checks++; if (done !== 1'b1 || {cout, sum} !== r) begin n_fail++; $display("FAIL stable_result: got done=%b %b/%h expected 1 %b/%h", done, cout, sum, r[W], r[W-1:0]); end
    @(posedge clock); #1;
  endtask

  task automatic test_dropped_request();
    apply_reset();
    a0 = 16'h0001; b0 = 16'h0002;
    for (int c = 0; c < 2 * (S + 2) + 1; c++) begin
      req0 = (c == 0);
      req1 = (c >= 2 && c < 4);
      @(negedge clock);
      n_checks++; if (gnt0 !== (c == 0) || gnt1 !== 1'b0) begin n_fail++; $display("FAIL drop_gnt_c%0d: got %b%b", c, gnt0, gnt1); end
      n_checks++; if (done !== (c == S + 1)) begin n_fail++; $display("FAIL drop_done_c%0d: got %b expected %b", c, done, (c == S + 1)); end
      @(posedge clock); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Timeline model: a grant happens only once the previous op's slot has ended.
  task automatic test_random();
    int         last_id = 1;
    int         free_at = 0;
    int         g_cyc   = 0;
    int         g;
    bit         have_op = 0;
    bit         p0 = 0, p1 = 0;
    bit         e_busy, e_done;
    logic [W:0] exp_res = '0;
    logic       exp_id  = 1'b0;
    apply_reset();
    for (int cyc = 0; cyc < N_RAND; cyc++) begin
      if (!p0) p0 = ($urandom_range(0, 2) == 0); else if ($urandom_range(0, 15) == 0) p0 = 0;
      if (!p1) p1 = ($urandom_range(0, 2) == 0); else if ($urandom_range(0, 15) == 0) p1 = 0;
      req0 = p0; req1 = p1;
      a0 = rand_operand(); b0 = rand_operand(); cin0 = 1'($urandom);
      a1 = rand_operand(); b1 = rand_operand(); cin1 = 1'($urandom);
      g = -1;
      if (cyc >= free_at) begin
        if (p0 && p1) g = (last_id == 1) ? 0 : 1;
        else if (p0)  g = 0;
        else if (p1)  g = 1;
      end
      e_busy = have_op && cyc > g_cyc && cyc <= g_cyc + S + 1;
      e_done = have_op && cyc == g_cyc + S + 1;
      @(negedge clock);
      n_checks++; if (gnt0 !== (g == 0) || gnt1 !== (g == 1)) begin n_fail++; $display("FAIL rand_gnt_c%0d: got %b%b expected %b%b", cyc, gnt0, gnt1, (g == 0), (g == 1)); end
      n_checks++; if (busy !== e_busy || done !== e_done) begin n_fail++; $display("FAIL rand_state_c%0d: got busy=%b done=%b expected %b %b", cyc, busy, done, e_busy, e_done); end
      if (have_op && cyc >= g_cyc + S + 1) begin
        n_checks++; if ({cout, sum} !== exp_res || done_id !== exp_id) begin n_fail++; $display("FAIL rand_result_c%0d: got %b/%h id=%b expected %b/%h id=%b", cyc, cout, sum, done_id, exp_res[W], exp_res[W-1:0], exp_id); end
      end
      if (g >= 0) begin
        have_op = 1;
        g_cyc   = cyc;
        free_at = cyc + S + 2;
        last_id = g;
        exp_id  = (g == 1);
        exp_res = (g == 0) ? ref_add(a0, b0, cin0) : ref_add(a1, b1, cin1);
        if (g == 0) p0 = 0; else p1 = 0;
      end
      @(posedge clock); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed_ops();
    test_reset();
    test_contention();
    test_abort();
    test_operand_stability();
    test_dropped_request();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
